// File: rtl/ga_mutator_pkg.sv
// Shared GA definitions: population geometry, FSM state encoding and LFSR constants.
// Imported by the mutation stage and by the selection stage's tournament logic.
package ga_pkg;

    localparam int POP_SIZE = 100;
    localparam int GENE_W   = 75;
    localparam int POP_W    = POP_SIZE * GENE_W;
    localparam int IDX_W    = $clog2(POP_SIZE);
    localparam int FLIP_W   = $clog2(POP_SIZE + 1);

    localparam logic [7:0]  GENE_W_B     = 8'(GENE_W);
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MUTATE,
        DONE
    } state_t;

    // Bit position inside one individual from the low LFSR byte. GENE_W >= 64
    // keeps the 7-bit draw below 2*GENE_W, so one subtract is enough.
    function automatic logic [7:0] fold_pos(input logic [7:0] raw);
        logic [7:0] p;
        p = raw & 8'h7F;
        return (p >= GENE_W_B) ? p - GENE_W_B : p;
    endfunction

endpackage

// File: rtl/ga_mutator_if.sv
// Controller <-> mutation-stage handshake: level start, population in,
// mutated population and status out.
interface ga_mutator_if;
    import ga_pkg::*;

    logic              mut_start;
    logic [POP_W-1:0]  population;
    logic [POP_W-1:0]  mut_pop;
    logic              mut_done;
    logic              busy;
    logic [FLIP_W-1:0] flip_count;

    modport master (
        output mut_start,
        output population,
        input  mut_pop,
        input  mut_done,
        input  busy,
        input  flip_count
    );

    modport slave (
        input  mut_start,
        input  population,
        output mut_pop,
        output mut_done,
        output busy,
        output flip_count
    );

endinterface

// File: rtl/ga_mutator_lfsr16.sv
// 16-bit right-shifting Galois LFSR (x^16+x^14+x^13+x^11+1); a zero seed
// would lock up, so it is replaced by the default seed.
module lfsr16
    import ga_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] seed_eff;
    logic [15:0] q_r;

    assign seed_eff = (seed == 16'h0000) ? DEFAULT_SEED : seed;
    assign q        = q_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= seed_eff;
        end else if (en) begin
            q_r <= {1'b0, q_r[15:1]} ^ (q_r[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/ga_mutator.sv
// Mutation stage: snapshots the population, walks one individual per cycle and
// flips at most one LFSR-chosen gene bit per individual (individual 0 is elite).
module ga_mutator
    import ga_pkg::*;
#(
    parameter logic [7:0]  MUT_RATE = 8'd26,
    parameter logic [15:0] SEED     = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    ga_mutator_if.slave bus
);

    state_t            state;
    logic              start_q;
    logic [IDX_W-1:0]  idx;
    logic [FLIP_W-1:0] flip_cnt;
    logic [15:0]       lfsr_q;
    logic              lfsr_en;

    logic [GENE_W-1:0] work [POP_SIZE];
    logic [POP_W-1:0]  work_flat;
    logic [7:0]        gene_pos;
    logic [GENE_W-1:0] gene_mask;
    logic              do_flip;

    logic [POP_W-1:0]  mut_pop_q;
    logic              mut_done_q;
    logic              busy_q;
    logic [FLIP_W-1:0] flip_count_q;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(POP_SIZE - 1);

    assign bus.mut_pop    = mut_pop_q;
    assign bus.mut_done   = mut_done_q;
    assign bus.busy       = busy_q;
    assign bus.flip_count = flip_count_q;

    assign lfsr_en = (state == MUTATE);

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (lfsr_en),
        .seed  (SEED),
        .q     (lfsr_q)
    );

    // A strict compare means a draw of 255 never flips, even at MUT_RATE = 255.
    assign gene_pos  = fold_pos(lfsr_q[7:0]);
    assign gene_mask = GENE_W'(1) << gene_pos;
    assign do_flip   = (state == MUTATE) && (idx != '0) && (lfsr_q[15:8] < MUT_RATE);

    for (genvar i = 0; i < POP_SIZE; i++) begin : g_pack
        assign work_flat[i*GENE_W +: GENE_W] = work[i];
    end

    // NOTE: the working copy is a plain data store with no reset; LOAD always
    // overwrites it before use, and only mut_pop is architecturally visible.
    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            for (int i = 0; i < POP_SIZE; i++) begin
                work[i] <= bus.population[i*GENE_W +: GENE_W];
            end
        end else if (do_flip) begin
            work[idx] <= work[idx] ^ gene_mask;
        end
    end

    // NOTE: all state and outputs update with non-blocking assignments so every
    // branch below reads the pre-edge values of the registers it tests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            start_q      <= 1'b0;
            idx          <= '0;
            flip_cnt     <= '0;
            mut_pop_q    <= '0;
            mut_done_q   <= 1'b0;
            busy_q       <= 1'b0;
            flip_count_q <= '0;
        end else begin
            start_q <= bus.mut_start;
            case (state)
                IDLE: begin
                    if (bus.mut_start && !start_q) begin
                        state  <= LOAD;
                        busy_q <= 1'b1;
                    end
                end
                LOAD: begin
                    idx      <= '0;
                    flip_cnt <= '0;
                    state    <= MUTATE;
                end
                MUTATE: begin
                    if (do_flip) begin
                        flip_cnt <= flip_cnt + FLIP_W'(1);
                    end
                    if (idx == LAST_IDX) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the result; mut_done low marks entry.
                    if (!mut_done_q) begin
                        mut_pop_q    <= work_flat;
                        flip_count_q <= flip_cnt;
                        mut_done_q   <= 1'b1;
                    end else if (!bus.mut_start) begin
                        mut_done_q <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ga_mutator.sv
// Self-checking bench for ga_mutator: three instances (rate 0, 255, default)
// compared against a behavioural mutation model driven by the LFSR recurrence.
module tb_ga_mutator;
    import ga_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   total_cnt = 0;
    int   pass_cnt  = 0;
    int   fail_cnt  = 0;

    always #5 clk = ~clk;

    ga_mutator_if if_r0 ();
    ga_mutator_if if_rmax ();
    ga_mutator_if if_def ();

    ga_mutator #(.MUT_RATE(8'd0))   dut_r0   (.clk(clk), .rst_n(rst_n), .bus(if_r0));
    ga_mutator #(.MUT_RATE(8'd255)) dut_rmax (.clk(clk), .rst_n(rst_n), .bus(if_rmax));
    ga_mutator                      dut_def  (.clk(clk), .rst_n(rst_n), .bus(if_def));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Number of individuals that differ between two flattened populations.
    function automatic int diff_inds(input logic [POP_W-1:0] a, input logic [POP_W-1:0] b);
        int n = 0;
        for (int i = 0; i < POP_SIZE; i++) begin
            if (a[i*GENE_W +: GENE_W] !== b[i*GENE_W +: GENE_W]) n++;
        end
        return n;
    endfunction

    // Reference mutation: one LFSR draw per individual, high byte against the
    // rate, low 7 bits modulo GENE_W as the bit to flip; individual 0 untouched.
    task automatic model_run(input logic [POP_W-1:0] pop, input int rate,
                             inout logic [15:0] s,
                             output logic [POP_W-1:0] res, output int flips);
        res   = pop;
        flips = 0;
        for (int k = 0; k < POP_SIZE; k++) begin
            int r;
            int p;
            r = int'(s[15:8]);
            p = int'(s[6:0]) % GENE_W;
            if (k != 0 && r < rate) begin
                res[k*GENE_W + p] = ~res[k*GENE_W + p];
                flips++;
            end
            s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [POP_W-1:0] pop_a5, pop_p, pop_q, exp1, exp2, exp3, expm;
    logic [15:0]      s_def, s_rmax;
    logic [7:0]       a5;
    int               f1, f2, f3, fm, bad;

    initial begin
        a5 = 8'hA5;
        for (int i = 0; i < POP_W; i++) begin
            pop_a5[i] = a5[i % 8];
            pop_p[i]  = 1'($urandom_range(0, 1));
            pop_q[i]  = 1'($urandom_range(0, 1));
        end
        s_def  = 16'hACE1;
        s_rmax = 16'hACE1;

        rst_n = 1'b0;
        if_r0.mut_start   = 1'b0; if_r0.population   = '0;
        if_rmax.mut_start = 1'b0; if_rmax.population = '0;
        if_def.mut_start  = 1'b0; if_def.population  = '0;
        edges(3);
        check("rst_done",  64'(if_def.mut_done), 64'd0);
        check("rst_busy",  64'(if_def.busy), 64'd0);
        check("rst_flip",  64'(if_def.flip_count), 64'd0);
        check("rst_pop",   64'(diff_inds(if_def.mut_pop, '0)), 64'd0);
        rst_n = 1'b1;
        edges(1);

        // Rate 0: output equals snapshot, done rises exactly at E0+102.
        if_r0.population = pop_a5;
        if_r0.mut_start  = 1'b1;
        edges(1);
        if_r0.mut_start  = 1'b0;
        edges(101);
        check("r0_done_e101", 64'(if_r0.mut_done), 64'd0);
        edges(1);
        check("r0_done_e102", 64'(if_r0.mut_done), 64'd1);
        check("r0_pop",       64'(diff_inds(if_r0.mut_pop, pop_a5)), 64'd0);
        check("r0_flip",      64'(if_r0.flip_count), 64'd0);
        edges(1);
        check("r0_done_fall", 64'(if_r0.mut_done), 64'd0);

        // Rate 255 on a zero population: result is exactly the flip pattern.
        if_rmax.mut_start = 1'b1;
        edges(1);
        if_rmax.mut_start = 1'b0;
        edges(102);
        model_run('0, 255, s_rmax, expm, fm);
        check("rmax_done",  64'(if_rmax.mut_done), 64'd1);
        check("rmax_pop",   64'(diff_inds(if_rmax.mut_pop, expm)), 64'd0);
        check("rmax_elite", 64'(if_rmax.mut_pop[GENE_W-1:0]), 64'd0);
        check("rmax_flip",  64'(if_rmax.flip_count), 64'(fm));
        check("rmax_ones",  64'($countones(if_rmax.mut_pop)), 64'(fm));
        bad = 0;
        for (int i = 0; i < POP_SIZE; i++) begin
            if ($countones(if_rmax.mut_pop[i*GENE_W +: GENE_W]) > 1) bad++;
        end
        check("rmax_le1", 64'(bad), 64'd0);

        // Four-phase: start held 300 cycles, no retrigger, done falls one edge after drop.
        if_def.population = pop_p;
        if_def.mut_start  = 1'b1;
        edges(1);
        edges(50);
        check("hold_busy", 64'(if_def.busy), 64'd1);
        edges(51);
        check("hold_done_e101", 64'(if_def.mut_done), 64'd0);
        edges(1);
        model_run(pop_p, 26, s_def, exp1, f1);
        check("hold_done_e102", 64'(if_def.mut_done), 64'd1);
        check("hold_pop",  64'(diff_inds(if_def.mut_pop, exp1)), 64'd0);
        check("hold_flip", 64'(if_def.flip_count), 64'(f1));
        bad = 0;
        for (int c = 0; c < 198; c++) begin
            @(negedge clk);
            if (if_def.mut_done !== 1'b1 || if_def.busy !== 1'b0) bad++;
        end
        check("hold_level", 64'(bad), 64'd0);
        check("hold_stable", 64'(diff_inds(if_def.mut_pop, exp1)), 64'd0);
        if_def.mut_start = 1'b0;
        edges(1);
        check("hold_release", 64'(if_def.mut_done), 64'd0);
        check("hold_keep",    64'(diff_inds(if_def.mut_pop, exp1)), 64'd0);

        // Early deassert, population altered mid-run; LFSR continues from run 1.
        if_def.mut_start = 1'b1;
        edges(1);
        if_def.mut_start = 1'b0;
        edges(9);
        if_def.population = pop_q;
        edges(92);
        check("early_done_e101", 64'(if_def.mut_done), 64'd0);
        edges(1);
        model_run(pop_p, 26, s_def, exp2, f2);
        check("early_done_e102", 64'(if_def.mut_done), 64'd1);
        check("early_pop",  64'(diff_inds(if_def.mut_pop, exp2)), 64'd0);
        check("early_flip", 64'(if_def.flip_count), 64'(f2));
        check("consec_differ", 64'(diff_inds(if_def.mut_pop, exp1) > 0), 64'd1);
        edges(1);
        check("early_pulse", 64'(if_def.mut_done), 64'd0);
        check("early_busy",  64'(if_def.busy), 64'd0);

        // Reset mid-run clears everything at once; rerun reproduces run 1.
        if_def.population = pop_p;
        if_def.mut_start  = 1'b1;
        edges(1);
        if_def.mut_start  = 1'b0;
        edges(49);
        rst_n = 1'b0;
        #1;
        check("mrst_done", 64'(if_def.mut_done), 64'd0);
        check("mrst_busy", 64'(if_def.busy), 64'd0);
        check("mrst_pop",  64'(diff_inds(if_def.mut_pop, '0)), 64'd0);
        check("mrst_flip", 64'(if_def.flip_count), 64'd0);
        edges(1);
        rst_n = 1'b1;
        s_def = 16'hACE1;
        edges(1);
        if_def.mut_start = 1'b1;
        edges(1);
        if_def.mut_start = 1'b0;
        edges(102);
        model_run(pop_p, 26, s_def, exp3, f3);
        check("rerun_done",  64'(if_def.mut_done), 64'd1);
        check("rerun_model", 64'(diff_inds(if_def.mut_pop, exp3)), 64'd0);
        check("rerun_same",  64'(diff_inds(if_def.mut_pop, exp1)), 64'd0);
        check("rerun_flip",  64'(if_def.flip_count), 64'(f1));
        edges(2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
